// File: rtl/cali_rls_seq_pkg.sv
// Shared types and constants for the DCD-RLS calibration sequencer.
package cali_rls_seq_pkg;

    localparam int unsigned FLUSH_SAMPLES = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SWEEP   = 3'd1,
        ST_CLR     = 3'd2,
        ST_LMS     = 3'd3,
        ST_RLS_ACQ = 3'd4,
        ST_TRACK   = 3'd5,
        ST_FAIL    = 3'd6
    } state_e;

    // Registered control bundle driven towards the calibrator and status regs.
    typedef struct packed {
        logic       cali_en;
        logic       mode_rls;
        logic [2:0] sync_dly;
        logic       cali_nrst;
        logic       busy;
        logic       lock;
        logic       fail;
    } seq_out_t;

    localparam seq_out_t SEQ_OUT_RST = '{cali_en: 1'b0, mode_rls: 1'b0, sync_dly: 3'd0,
                                         cali_nrst: 1'b1, busy: 1'b0, lock: 1'b0, fail: 1'b0};

    // Accumulator width: one |ERR| per sample times the largest window.
    function automatic int unsigned acc_width(input int unsigned ew, input int unsigned wlog_max);
        return ew + wlog_max;
    endfunction

endpackage

// File: rtl/cali_err_win.sv
// Windowed sum of |ERR| with flush after arming and saturating accumulation.
module cali_err_win
    import cali_rls_seq_pkg::*;
#(
    parameter int unsigned EW       = 16,
    parameter int unsigned WLOG_MAX = 12,
    parameter int unsigned FLUSH    = FLUSH_SAMPLES,
    parameter int unsigned AW       = acc_width(EW, WLOG_MAX)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_arm,
    input  logic [3:0]    i_wlog,
    input  logic          i_err_vld,
    input  logic [EW-1:0] i_err,
    output logic [AW-1:0] o_metric,
    output logic          o_win_done
);

    localparam int unsigned CW = WLOG_MAX + 1;
    localparam int unsigned FW = $clog2(FLUSH + 2);
    localparam int unsigned SW = AW + 1;
    localparam logic [3:0]    WLOG_CAP = 4'(WLOG_MAX);
    localparam logic [EW-1:0] ERR_MIN  = {1'b1, {(EW-1){1'b0}}};

    logic [FW-1:0] r_flush_cnt;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_acc;
    logic [AW-1:0] r_metric;
    logic          r_win_done;
    logic [3:0]    r_wlog;

    logic [3:0]    w_wlog_clamp;
    logic [3:0]    w_wlog_eff;
    logic [CW-1:0] w_last_idx;
    logic [EW-1:0] w_abs;
    logic [SW-1:0] w_sum;
    logic [AW-1:0] w_acc_nxt;

    // Window length is taken from config only while no window is in progress.
    assign w_wlog_clamp = (i_wlog > WLOG_CAP) ? WLOG_CAP : i_wlog;
    assign w_wlog_eff   = (r_cnt == '0) ? w_wlog_clamp : r_wlog;
    assign w_last_idx   = (CW'(1) << w_wlog_eff) - CW'(1);

    // Saturating magnitude: the most negative code maps to the largest positive one.
    assign w_abs     = (i_err == ERR_MIN) ? ~ERR_MIN :
                       (i_err[EW-1] ? (~i_err + EW'(1)) : i_err);
    assign w_sum     = {1'b0, r_acc} + SW'(w_abs);
    assign w_acc_nxt = w_sum[AW] ? '1 : w_sum[AW-1:0];

    // Flush, accumulate and close windows; disarming clears everything but METRIC.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flush_cnt <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_metric    <= '0;
            r_win_done  <= 1'b0;
            r_wlog      <= '0;
        end else begin
            r_win_done <= 1'b0;
            r_wlog     <= w_wlog_eff;
            if (!i_arm) begin
                r_flush_cnt <= '0;
                r_cnt       <= '0;
                r_acc       <= '0;
            end else if (i_err_vld) begin
                if (r_flush_cnt < FW'(FLUSH)) begin
                    r_flush_cnt <= r_flush_cnt + FW'(1);
                end else if (r_cnt == w_last_idx) begin
                    r_metric   <= w_acc_nxt;
                    r_win_done <= 1'b1;
                    r_acc      <= '0;
                    r_cnt      <= '0;
                end else begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign o_metric   = r_metric;
    assign o_win_done = r_win_done;

endmodule

// File: rtl/cali_rls_seq.sv
// Calibration sequencer: delay sweep, LMS warm-up, RLS acquisition and lock tracking.
module cali_rls_seq
    import cali_rls_seq_pkg::*;
#(
    parameter  int unsigned EW       = 16,
    parameter  int unsigned WLOG_MAX = 12,
    parameter  int unsigned FLUSH    = FLUSH_SAMPLES,
    localparam int unsigned AW       = acc_width(EW, WLOG_MAX)
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_err_vld,
    input  logic [EW-1:0] i_err,
    input  logic [3:0]    i_cfg_wlog,
    input  logic [3:0]    i_cfg_lms_wins,
    input  logic [7:0]    i_cfg_max_wins,
    input  logic [AW-1:0] i_cfg_lock_thr,
    input  logic [AW-1:0] i_cfg_unlock_thr,
    output logic          o_cali_en,
    output logic          o_cali_mode_rls,
    output logic [2:0]    o_sync_dly,
    output logic          o_cali_nrst,
    output logic          o_busy,
    output logic          o_lock,
    output logic          o_fail,
    output logic [AW-1:0] o_metric
);

    state_e        r_state,   w_state_nxt;
    logic [2:0]    r_d,       w_d_nxt;
    logic [AW-1:0] r_best,    w_best_nxt;
    logic [2:0]    r_best_d,  w_best_d_nxt;
    logic [7:0]    r_win_cnt, w_win_cnt_nxt;
    logic          r_clr_ph,  w_clr_ph_nxt;
    logic          r_bad,     w_bad_nxt;
    logic          r_arm,     w_arm_nxt;
    seq_out_t      r_out,     w_out_nxt;
    logic [AW-1:0] r_metric,  w_metric_nxt;

    logic [AW-1:0] w_win_metric;
    logic          w_win_done;
    logic          w_arm;
    logic          w_better;
    logic [7:0]    w_win_inc;

    // Abort disarms the window engine in the same cycle so the accumulator clears at once.
    assign w_arm     = r_arm & ~i_abort;
    assign w_better  = w_win_metric < r_best;
    assign w_win_inc = r_win_cnt + 8'd1;

    cali_err_win #(
        .EW       (EW),
        .WLOG_MAX (WLOG_MAX),
        .FLUSH    (FLUSH),
        .AW       (AW)
    ) u_win (
        .i_clk      (i_clk),
        .i_rst_n    (i_nrst),
        .i_arm      (w_arm),
        .i_wlog     (i_cfg_wlog),
        .i_err_vld  (i_err_vld),
        .i_err      (i_err),
        .o_metric   (w_win_metric),
        .o_win_done (w_win_done)
    );

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state   <= ST_IDLE;
            r_d       <= '0;
            r_best    <= '1;
            r_best_d  <= '0;
            r_win_cnt <= '0;
            r_clr_ph  <= 1'b0;
            r_bad     <= 1'b0;
            r_arm     <= 1'b0;
            r_out     <= SEQ_OUT_RST;
            r_metric  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_d       <= w_d_nxt;
            r_best    <= w_best_nxt;
            r_best_d  <= w_best_d_nxt;
            r_win_cnt <= w_win_cnt_nxt;
            r_clr_ph  <= w_clr_ph_nxt;
            r_bad     <= w_bad_nxt;
            r_arm     <= w_arm_nxt;
            r_out     <= w_out_nxt;
            r_metric  <= w_metric_nxt;
        end
    end

    // Next-state and next-output decode; dropping arm for a cycle forces a re-flush.
    always_comb begin
        w_state_nxt   = r_state;
        w_d_nxt       = r_d;
        w_best_nxt    = r_best;
        w_best_d_nxt  = r_best_d;
        w_win_cnt_nxt = r_win_cnt;
        w_clr_ph_nxt  = r_clr_ph;
        w_bad_nxt     = r_bad;
        w_arm_nxt     = r_arm;
        w_out_nxt     = r_out;
        w_metric_nxt  = r_metric;

        if (i_abort) begin
            w_state_nxt         = ST_IDLE;
            w_arm_nxt           = 1'b0;
            w_out_nxt.cali_en   = 1'b0;
            w_out_nxt.mode_rls  = 1'b0;
            w_out_nxt.cali_nrst = 1'b1;
            w_out_nxt.busy      = 1'b0;
            w_out_nxt.lock      = 1'b0;
            w_out_nxt.fail      = 1'b0;
        end else begin
            if (w_win_done) begin
                w_metric_nxt = w_win_metric;
            end
            unique case (r_state)
                ST_IDLE, ST_FAIL: begin
                    w_arm_nxt = 1'b0;
                    if (i_start) begin
                        w_state_nxt  = ST_SWEEP;
                        w_d_nxt      = 3'd0;
                        w_best_nxt   = '1;
                        w_best_d_nxt = 3'd0;
                        w_out_nxt    = '{cali_en: 1'b1, mode_rls: 1'b0, sync_dly: 3'd0,
                                         cali_nrst: 1'b1, busy: 1'b1, lock: 1'b0, fail: 1'b0};
                    end
                end
                ST_SWEEP: begin
                    w_arm_nxt = 1'b1;
                    if (w_win_done) begin
                        w_arm_nxt = 1'b0;
                        if (w_better) begin
                            w_best_nxt   = w_win_metric;
                            w_best_d_nxt = r_d;
                        end
                        if (r_d == 3'd7) begin
                            w_state_nxt         = ST_CLR;
                            w_clr_ph_nxt        = 1'b0;
                            w_out_nxt.sync_dly  = w_better ? r_d : r_best_d;
                            w_out_nxt.cali_en   = 1'b0;
                            w_out_nxt.cali_nrst = 1'b0;
                        end else begin
                            w_d_nxt            = r_d + 3'd1;
                            w_out_nxt.sync_dly = r_d + 3'd1;
                        end
                    end
                end
                ST_CLR: begin
                    w_arm_nxt = 1'b0;
                    if (!r_clr_ph) begin
                        w_clr_ph_nxt        = 1'b1;
                        w_out_nxt.cali_nrst = 1'b1;
                    end else begin
                        w_win_cnt_nxt     = 8'd0;
                        w_out_nxt.cali_en = 1'b1;
                        if (i_cfg_lms_wins == 4'd0) begin
                            w_state_nxt        = ST_RLS_ACQ;
                            w_out_nxt.mode_rls = 1'b1;
                        end else begin
                            w_state_nxt        = ST_LMS;
                            w_out_nxt.mode_rls = 1'b0;
                        end
                    end
                end
                ST_LMS: begin
                    w_arm_nxt = 1'b1;
                    if (w_win_done) begin
                        w_win_cnt_nxt = w_win_inc;
                        if (w_win_inc >= {4'd0, i_cfg_lms_wins}) begin
                            w_state_nxt        = ST_RLS_ACQ;
                            w_win_cnt_nxt      = 8'd0;
                            w_arm_nxt          = 1'b0;
                            w_out_nxt.mode_rls = 1'b1;
                        end
                    end
                end
                ST_RLS_ACQ: begin
                    w_arm_nxt = 1'b1;
                    if (w_win_done) begin
                        if (w_win_metric <= i_cfg_lock_thr) begin
                            w_state_nxt    = ST_TRACK;
                            w_bad_nxt      = 1'b0;
                            w_out_nxt.lock = 1'b1;
                        end else begin
                            w_win_cnt_nxt = w_win_inc;
                            if ((i_cfg_max_wins != 8'd0) && (w_win_inc >= i_cfg_max_wins)) begin
                                w_state_nxt       = ST_FAIL;
                                w_arm_nxt         = 1'b0;
                                w_out_nxt.fail    = 1'b1;
                                w_out_nxt.cali_en = 1'b0;
                                w_out_nxt.busy    = 1'b0;
                            end
                        end
                    end
                end
                ST_TRACK: begin
                    w_arm_nxt = 1'b1;
                    if (w_win_done) begin
                        if (w_win_metric > i_cfg_unlock_thr) begin
                            if (r_bad) begin
                                w_state_nxt         = ST_CLR;
                                w_clr_ph_nxt        = 1'b0;
                                w_bad_nxt           = 1'b0;
                                w_arm_nxt           = 1'b0;
                                w_out_nxt.lock      = 1'b0;
                                w_out_nxt.cali_en   = 1'b0;
                                w_out_nxt.cali_nrst = 1'b0;
                            end else begin
                                w_bad_nxt = 1'b1;
                            end
                        end else begin
                            w_bad_nxt = 1'b0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_arm_nxt   = 1'b0;
                    w_out_nxt   = SEQ_OUT_RST;
                end
            endcase
        end
    end

    assign o_cali_en       = r_out.cali_en;
    assign o_cali_mode_rls = r_out.mode_rls;
    assign o_sync_dly      = r_out.sync_dly;
    assign o_cali_nrst     = r_out.cali_nrst;
    assign o_busy          = r_out.busy;
    assign o_lock          = r_out.lock;
    assign o_fail          = r_out.fail;
    assign o_metric        = r_metric;

endmodule

// File: tb/tb_cali_rls_seq.sv
// Directed bench for the calibration sequencer; the bench plays the calibrator's ERR source.
module tb_cali_rls_seq;

    localparam int unsigned EW = 16;
    localparam int unsigned AW = 28;
    localparam logic [8:0]  OUT_RST = 9'b0_0_000_1_0_0_0;

    logic          clk;
    logic          i_nrst, i_start, i_abort, i_err_vld;
    logic [EW-1:0] i_err;
    logic [3:0]    i_cfg_wlog, i_cfg_lms_wins;
    logic [7:0]    i_cfg_max_wins;
    logic [AW-1:0] i_cfg_lock_thr, i_cfg_unlock_thr;
    logic          o_cali_en, o_cali_mode_rls, o_cali_nrst, o_busy, o_lock, o_fail;
    logic [2:0]    o_sync_dly;
    logic [AW-1:0] o_metric;

    int            n_total;
    int            n_bad;
    logic [EW-1:0] tbl [8];
    logic [EW-1:0] rls_err;

    cali_rls_seq #(.EW(EW), .WLOG_MAX(12)) dut (
        .i_clk            (clk),
        .i_nrst           (i_nrst),
        .i_start          (i_start),
        .i_abort          (i_abort),
        .i_err_vld        (i_err_vld),
        .i_err            (i_err),
        .i_cfg_wlog       (i_cfg_wlog),
        .i_cfg_lms_wins   (i_cfg_lms_wins),
        .i_cfg_max_wins   (i_cfg_max_wins),
        .i_cfg_lock_thr   (i_cfg_lock_thr),
        .i_cfg_unlock_thr (i_cfg_unlock_thr),
        .o_cali_en        (o_cali_en),
        .o_cali_mode_rls  (o_cali_mode_rls),
        .o_sync_dly       (o_sync_dly),
        .o_cali_nrst      (o_cali_nrst),
        .o_busy           (o_busy),
        .o_lock           (o_lock),
        .o_fail           (o_fail),
        .o_metric         (o_metric)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {o_cali_en, o_cali_mode_rls, o_sync_dly, o_cali_nrst, o_busy, o_lock, o_fail};
    endfunction

    // Advance to the next falling edge and present ERR as the calibrator would.
    task automatic step();
        @(negedge clk);
        i_err = o_cali_mode_rls ? rls_err : tbl[o_sync_dly];
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic do_abort();
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        step();
    endtask

    task automatic fill_tbl(input logic [EW-1:0] v);
        for (int i = 0; i < 8; i++) tbl[i] = v;
    endtask

    task automatic test_reset();
        int saw_clr;
        i_nrst = 1'b0;
        repeat (3) step();
        n_total++;
        if (outs() !== OUT_RST || o_metric !== '0) begin
            n_bad++; $display("FAIL reset_init: outs=%b metric=%0d exp outs=%b metric=0", outs(), o_metric, OUT_RST);
        end
        i_nrst = 1'b1;
        step();
        fill_tbl(16'hFF9C);
        pulse_start();
        repeat (29) step();
        n_total++;
        if (o_metric !== 28'd1600 || o_busy !== 1'b1 || o_cali_en !== 1'b1) begin
            n_bad++; $display("FAIL sweep_d0_window: metric=%0d busy=%b en=%b exp 1600 1 1", o_metric, o_busy, o_cali_en);
        end
        saw_clr = 0;
        i_nrst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            if (!o_cali_nrst) saw_clr++;
        end
        n_total++;
        if (outs() !== OUT_RST || o_metric !== '0) begin
            n_bad++; $display("FAIL reset_mid_sweep: outs=%b metric=%0d exp outs=%b metric=0", outs(), o_metric, OUT_RST);
        end
        i_nrst = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step();
            if (!o_cali_nrst) saw_clr++;
        end
        n_total++;
        if (outs() !== OUT_RST || saw_clr != 0) begin
            n_bad++; $display("FAIL reset_release_idle: outs=%b clr_cycles=%0d exp outs=%b clr_cycles=0", outs(), saw_clr, OUT_RST);
        end
    endtask

    task automatic test_sweep_select();
        int k;
        int lowc;
        fill_tbl(16'd100);
        tbl[1] = 16'hFF9C;
        tbl[5] = 16'd3;
        pulse_start();
        k = 0;
        while (o_sync_dly !== 3'd6 && k < 1000) begin step(); k++; end
        n_total++;
        if (o_sync_dly !== 3'd6 || o_metric !== 28'd48) begin
            n_bad++; $display("FAIL sweep_d5_metric: dly=%0d metric=%0d exp dly=6 metric=48", o_sync_dly, o_metric);
        end
        k = 0;
        while (o_cali_nrst !== 1'b0 && k < 1000) begin step(); k++; end
        n_total++;
        if (o_sync_dly !== 3'd5 || o_cali_en !== 1'b0 || o_cali_nrst !== 1'b0) begin
            n_bad++; $display("FAIL sweep_best_d: dly=%0d en=%b nrst=%b exp dly=5 en=0 nrst=0", o_sync_dly, o_cali_en, o_cali_nrst);
        end
        lowc = 0;
        for (int j = 0; j < 4; j++) begin
            if (!o_cali_nrst) lowc++;
            step();
        end
        n_total++;
        if (lowc != 1) begin
            n_bad++; $display("FAIL clr_pulse_len: got %0d cycles exp 1", lowc);
        end
        n_total++;
        if (o_cali_en !== 1'b1 || o_cali_mode_rls !== 1'b0 || o_busy !== 1'b1) begin
            n_bad++; $display("FAIL lms_entry: en=%b mode=%b busy=%b exp 1 0 1", o_cali_en, o_cali_mode_rls, o_busy);
        end
        do_abort();
        n_total++;
        if (o_busy !== 1'b0 || o_cali_en !== 1'b0) begin
            n_bad++; $display("FAIL abort_idle: busy=%b en=%b exp 0 0", o_busy, o_cali_en);
        end
    endtask

    task automatic test_sweep_tie();
        int k;
        fill_tbl(16'd100);
        tbl[2] = 16'd3;
        tbl[5] = 16'd3;
        pulse_start();
        k = 0;
        while (o_cali_nrst !== 1'b0 && k < 1000) begin step(); k++; end
        n_total++;
        if (o_sync_dly !== 3'd2 || o_metric !== 28'd1600 || o_cali_nrst !== 1'b0) begin
            n_bad++; $display("FAIL sweep_tie: dly=%0d metric=%0d nrst=%b exp dly=2 metric=1600 nrst=0", o_sync_dly, o_metric, o_cali_nrst);
        end
        do_abort();
    endtask

    task automatic test_lock_path();
        int k;
        fill_tbl(16'd100);
        tbl[3] = 16'd3;
        rls_err          = 16'd2;
        i_cfg_lms_wins   = 4'd2;
        i_cfg_lock_thr   = 28'd64;
        i_cfg_unlock_thr = 28'd200;
        i_cfg_max_wins   = 8'd0;
        pulse_start();
        k = 0;
        while (o_cali_nrst !== 1'b0 && k < 1000) begin step(); k++; end
        k = 0;
        while (o_cali_en !== 1'b1 && k < 10) begin step(); k++; end
        n_total++;
        if (o_cali_en !== 1'b1 || o_sync_dly !== 3'd3 || o_cali_mode_rls !== 1'b0) begin
            n_bad++; $display("FAIL lms_start: en=%b dly=%0d mode=%b exp 1 3 0", o_cali_en, o_sync_dly, o_cali_mode_rls);
        end
        k = 0;
        while (o_cali_mode_rls !== 1'b1 && k < 200) begin step(); k++; end
        n_total++;
        if (k != 42) begin
            n_bad++; $display("FAIL lms_duration: mode rose after %0d cycles exp 42", k);
        end
        k = 0;
        while (o_lock !== 1'b1 && k < 200) begin step(); k++; end
        n_total++;
        if (k != 26 || o_metric !== 28'd32) begin
            n_bad++; $display("FAIL rls_lock: lock after %0d cycles metric=%0d exp 26 cycles metric=32", k, o_metric);
        end
    endtask

    task automatic test_unlock();
        int lowc;
        int first_unlock;
        lowc = 0;
        first_unlock = -1;
        for (int i = 1; i <= 90; i++) begin
            rls_err = ((i >= 15 && i <= 30) || (i >= 47 && i <= 78)) ? 16'd20 : 16'd2;
            step();
            if (!o_cali_nrst) lowc++;
            if (!o_lock && first_unlock < 0) first_unlock = i;
            if (i == 33) begin
                n_total++;
                if (o_lock !== 1'b1 || o_metric !== 28'd320) begin
                    n_bad++; $display("FAIL one_bad_window: lock=%b metric=%0d exp lock=1 metric=320", o_lock, o_metric);
                end
            end
            if (i == 49) begin
                n_total++;
                if (o_lock !== 1'b1 || o_metric !== 28'd32) begin
                    n_bad++; $display("FAIL bad_run_reset: lock=%b metric=%0d exp lock=1 metric=32", o_lock, o_metric);
                end
            end
            if (i == 80) begin
                n_total++;
                if (o_cali_nrst !== 1'b0 || o_sync_dly !== 3'd3 || o_cali_en !== 1'b0) begin
                    n_bad++; $display("FAIL relock_clr: nrst=%b dly=%0d en=%b exp 0 3 0", o_cali_nrst, o_sync_dly, o_cali_en);
                end
            end
        end
        n_total++;
        if (first_unlock != 80 || lowc != 1) begin
            n_bad++; $display("FAIL unlock_timing: unlock at %0d clr_cycles=%0d exp 80 and 1", first_unlock, lowc);
        end
        do_abort();
    endtask

    task automatic test_timeout();
        int k;
        fill_tbl(16'h8000);
        rls_err        = 16'h8000;
        i_cfg_lms_wins = 4'd0;
        i_cfg_max_wins = 8'd3;
        i_cfg_lock_thr = 28'd0;
        pulse_start();
        k = 0;
        while (o_cali_mode_rls !== 1'b1 && k < 1000) begin step(); k++; end
        n_total++;
        if (o_cali_mode_rls !== 1'b1 || o_cali_en !== 1'b1 || o_sync_dly !== 3'd0) begin
            n_bad++; $display("FAIL skip_lms: mode=%b en=%b dly=%0d exp 1 1 0", o_cali_mode_rls, o_cali_en, o_sync_dly);
        end
        k = 0;
        while (o_fail !== 1'b1 && k < 200) begin step(); k++; end
        n_total++;
        if (k != 58 || o_metric !== 28'd524272) begin
            n_bad++; $display("FAIL timeout: fail after %0d cycles metric=%0d exp 58 cycles metric=524272", k, o_metric);
        end
        repeat (5) step();
        n_total++;
        if (o_fail !== 1'b1 || o_cali_en !== 1'b0 || o_busy !== 1'b0) begin
            n_bad++; $display("FAIL fail_hold: fail=%b en=%b busy=%b exp 1 0 0", o_fail, o_cali_en, o_busy);
        end
        pulse_start();
        n_total++;
        if (o_fail !== 1'b0 || o_cali_en !== 1'b1 || o_busy !== 1'b1 || o_sync_dly !== 3'd0 || o_cali_mode_rls !== 1'b0) begin
            n_bad++; $display("FAIL restart_from_fail: outs=%b exp %b", outs(), 9'b1_0_000_1_1_0_0);
        end
        do_abort();
    endtask

    task automatic test_abort_collision();
        fill_tbl(16'd5);
        pulse_start();
        repeat (25) step();
        i_abort = 1'b1;
        i_start = 1'b1;
        step();
        i_abort = 1'b0;
        i_start = 1'b0;
        n_total++;
        if (outs() !== OUT_RST || o_metric !== 28'd524272) begin
            n_bad++; $display("FAIL abort_collision: outs=%b metric=%0d exp outs=%b metric=524272", outs(), o_metric, OUT_RST);
        end
        repeat (30) step();
        n_total++;
        if (o_busy !== 1'b0 || o_cali_en !== 1'b0 || o_metric !== 28'd524272) begin
            n_bad++; $display("FAIL abort_stays_idle: busy=%b en=%b metric=%0d exp 0 0 524272", o_busy, o_cali_en, o_metric);
        end
    endtask

    initial begin
        n_total          = 0;
        n_bad            = 0;
        i_nrst           = 1'b0;
        i_start          = 1'b0;
        i_abort          = 1'b0;
        i_err_vld        = 1'b1;
        i_err            = '0;
        i_cfg_wlog       = 4'd4;
        i_cfg_lms_wins   = 4'd2;
        i_cfg_max_wins   = 8'd0;
        i_cfg_lock_thr   = 28'd0;
        i_cfg_unlock_thr = 28'd200;
        rls_err          = '0;
        fill_tbl('0);

        test_reset();
        test_sweep_select();
        test_sweep_tie();
        test_lock_path();
        test_unlock();
        test_timeout();
        test_abort_collision();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cali_rls_seq.md
Name: cali_rls_seq

Overview:
- Calibration sequencer for the piecewise DCD-RLS DTC-gain calibrator.
- Drives its EN, CALI_MODE_RLS, sync_dly and a local engine-clear reset.
- Sequence: find the best ERR/X alignment delay, warm up in LMS mode, then switch to RLS.
- Monitors windowed |ERR| to declare and supervise lock. Sits between the digital top-level control registers and the calibrator.

Parameters:
- EW, 16, ERR input width (signed two's complement, fixed-point copy of ERR).
- WLOG_MAX, 12, maximum window size log2; accumulator width AW = EW+WLOG_MAX.
- FLUSH, 8, valid samples discarded after any SYNC_DLY or mode change.

Ports:
- CLK  in  1  clock
- NRST  in  1  async active-low reset
- START  in  1  1-cycle pulse; begin calibration
- ABORT  in  1  level; force return to IDLE
- ERR_VLD  in  1  ERR sample valid this cycle
- ERR  in  EW  signed error sample
- CFG_WLOG  in  4  window = 2^CFG_WLOG valid samples (values >WLOG_MAX clamp to WLOG_MAX)
- CFG_LMS_WINS  in  4  LMS warm-up windows (0 = skip LMS)
- CFG_MAX_WINS  in  8  RLS acquisition timeout, in windows
- CFG_LOCK_THR  in  AW  lock when metric <= threshold
- CFG_UNLOCK_THR  in  AW  unlock when metric > threshold
- CALI_EN  out  1  calibrator EN
- CALI_MODE_RLS  out  1  0 = LMS, 1 = RLS
- SYNC_DLY  out  3  calibrator sync_dly
- CALI_NRST  out  1  engine clear, active-low
- BUSY  out  1  not in IDLE/FAIL
- LOCK  out  1  metric within threshold
- FAIL  out  1  acquisition timeout
- METRIC  out  AW  last completed window sum of |ERR|

Behaviour:
- Reset values: CALI_EN=0, CALI_MODE_RLS=0, SYNC_DLY=0, CALI_NRST=1, BUSY=0, LOCK=0, FAIL=0, METRIC=0; state IDLE.
- Reset is asynchronous, active-low, and allowed mid-operation with the same result.
- All outputs are registered.
- Window engine:
  - |ERR| is computed with saturation: -2^(EW-1) maps to 2^(EW-1)-1.
  - Only samples with ERR_VLD are accumulated; the accumulator saturates at 2^AW-1.
  - After 2^CFG_WLOG samples, METRIC is loaded and a win_done pulse fires 1 cycle after the last sample. The accumulator then restarts.
  - Flush: the first FLUSH valid samples after arming are not counted.
- States:
  - IDLE: CALI_EN=0. START -> SWEEP with d=0, best=max, best_d=0. START is ignored in every other state except FAIL.
  - SWEEP: CALI_EN=1, MODE=0, SYNC_DLY=d. Flush, then one window.
    - If metric < best (strict, so ties keep the lower d), update best and best_d.
    - d=7 done -> CLR with SYNC_DLY=best_d; else d+1 and re-flush.
  - CLR: 2 cycles. Cycle 1 drives CALI_NRST=0 and CALI_EN=0; cycle 2 drives CALI_NRST=1. Then go to LMS, or to RLS_ACQ if CFG_LMS_WINS=0.
  - LMS: CALI_EN=1, MODE=0. Flush, then CFG_LMS_WINS windows -> RLS_ACQ.
  - RLS_ACQ: MODE=1 (the change is registered, so it never toggles mid-window). Flush, then count windows.
    - metric <= LOCK_THR -> TRACK with LOCK=1.
    - Window count reaching CFG_MAX_WINS without lock -> FAIL. CFG_MAX_WINS=0 means no timeout.
  - TRACK: LOCK=1 and windows run continuously with no flush. Two consecutive windows with metric > UNLOCK_THR -> LOCK=0 and go to CLR (relock keeps SYNC_DLY; no re-sweep).
  - FAIL: CALI_EN=0, FAIL=1. FAIL stays set until START or ABORT; START clears it and goes to SWEEP.
- ABORT, from any state: next cycle is IDLE, CALI_EN=0, LOCK=0, FAIL=0, CALI_NRST=1, accumulator cleared. ABORT has priority over START and over win_done in the same cycle.
- Config inputs are sampled only at window start; a change mid-window takes effect on the next window.

Decomposition:
- Package cali_rls_seq_pkg: state enum (IDLE, SWEEP, CLR, LMS, RLS_ACQ, TRACK, FAIL), FLUSH constant, AW localparam function.
- Sub-module cali_err_win:
  - Inputs: arm, wlog, err_vld, err.
  - Outputs: metric, win_done.
  - Handles abs/saturation, flush counting and window counting.
- The FSM lives in cali_rls_seq.

Test Plan:
- Reset mid-SWEEP with NRST low for 3 cycles -> all outputs at reset values, state IDLE, no CALI_NRST pulse.
- Sweep selection: CFG_WLOG=4; ERR magnitude 100 for d≠5 and 3 for d=5 -> SYNC_DLY=5 after sweep; CALI_NRST low exactly 1 cycle; METRIC=48 after the d=5 window. Tie case: d=2 and d=5 both 3 -> SYNC_DLY=2.
- Lock path: CFG_LMS_WINS=2, LOCK_THR=64, ERR=2 in RLS -> MODE rises after 2 LMS windows plus flush; LOCK=1 the cycle after the first RLS window (METRIC=32).
- Unlock: in TRACK, UNLOCK_THR=200; one window with ERR=20 (METRIC=320) -> LOCK stays 1; two consecutive -> LOCK=0, CLR pulse, SYNC_DLY unchanged.
- Timeout and saturation: CFG_MAX_WINS=3 with ERR=-32768 -> |ERR|=32767 per sample; FAIL=1 and CALI_EN=0 after the 3rd window; START -> FAIL clears and SWEEP restarts at d=0.
- ABORT asserted in the same cycle as START and win_done -> IDLE, no METRIC update, CALI_EN=0 next cycle.
